// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the second-generation system controller: command codes,
// FSM state encoding and the fixed register-file addresses used for ALU operands.
package sys_ctrl_pkg;

  localparam logic [7:0] CMD_WR       = 8'hAA;
  localparam logic [7:0] CMD_RD       = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP  = 8'hDD;
  localparam logic [7:0] CMD_BURST_WR = 8'hEE;

  localparam int unsigned ADDR_OP_A = 0;
  localparam int unsigned ADDR_OP_B = 1;

  typedef enum logic [3:0] {
    StIdle,
    StWrAddr,
    StWrData,
    StRdAddr,
    StRdWait,
    StAluA,
    StAluB,
    StAluFun,
    StAluWait,
    StBwAddr,
    StBwCnt,
    StBwData,
    StTxSend
  } state_e;

endpackage

// File: rtl/sys_ctrl_tx_ser.sv
// Result serialiser: loads up to OUT_BYTES bytes and emits them LSB first, one per cycle
// while the TX FIFO is not full; done marks the cycle the last byte is written.
module sys_ctrl_tx_ser #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_BYTES  = 2,
  localparam int unsigned ResW      = OUT_BYTES * DATA_WIDTH,
  localparam int unsigned NumW      = $clog2(OUT_BYTES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ResW-1:0]       load_data,
  input  logic [NumW-1:0]       load_cnt,
  input  logic                  wfull,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_vld,
  output logic                  done
);

  logic [ResW-1:0] data_q, data_d;
  logic [NumW-1:0] left_q, left_d;
  logic            active;

  assign active  = (left_q != '0);
  assign tx_vld  = active && !wfull;
  assign tx_data = active ? data_q[DATA_WIDTH-1:0] : '0;
  assign done    = tx_vld && (left_q == NumW'(1));

  always_comb begin
    data_d = data_q;
    left_d = left_q;
    if (load) begin
      data_d = load_data;
      left_d = load_cnt;
    end else if (tx_vld) begin
      // Shifting keeps the next byte in the low lane so no variable index is needed.
      data_d = data_q >> DATA_WIDTH;
      left_d = left_q - NumW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      left_q <= '0;
    end else begin
      data_q <= data_d;
      left_q <= left_d;
    end
  end

endmodule

// File: rtl/sys_ctrl_gen2.sv
// System controller: decodes framed UART commands into register-file, ALU and burst-write
// transactions, enforces a per-byte frame timeout and serialises results to the TX FIFO.
module sys_ctrl_gen2
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FUN_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned OUT_BYTES      = 2
) (
  input  logic                              CLK,
  input  logic                              RST,
  input  logic [DATA_WIDTH-1:0]             RX_P_Data,
  input  logic                              RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]             RdData,
  input  logic                              RdData_Valid,
  input  logic [OUT_BYTES*DATA_WIDTH-1:0]   ALU_OUT,
  input  logic                              OUT_Valid,
  input  logic                              wfull,
  output logic [ADDR_WIDTH-1:0]             Address,
  output logic                              Wr_En,
  output logic                              Rd_En,
  output logic [DATA_WIDTH-1:0]             Wr_Data,
  output logic                              ALU_EN,
  output logic [FUN_WIDTH-1:0]              ALU_FUN,
  output logic                              CLK_GATING_EN,
  output logic [DATA_WIDTH-1:0]             TX_P_Data,
  output logic                              TX_D_VLD,
  output logic                              clk_div_en,
  output logic                              frame_err
);

  localparam int unsigned ResW = OUT_BYTES * DATA_WIDTH;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned NumW = $clog2(OUT_BYTES + 1);

  state_e state_q, state_d;

  logic [CntW-1:0]       to_cnt_q, to_cnt_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic [ADDR_WIDTH-1:0] bw_addr_q, bw_addr_d;
  logic [DATA_WIDTH-1:0] bw_cnt_q, bw_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  alu_en_q, alu_en_d;
  logic                  gating_q, gating_d;
  logic                  frame_err_q, frame_err_d;
  logic                  clk_div_en_q;

  logic                  cmd_known;
  logic                  rx_accept;
  logic                  rsp_event;
  logic                  counting;
  logic                  timeout_fire;
  logic                  ser_load;
  logic [ResW-1:0]       ser_data;
  logic [NumW-1:0]       ser_cnt;
  logic                  ser_done;

  assign cmd_known = (RX_P_Data == DATA_WIDTH'(CMD_WR))      ||
                     (RX_P_Data == DATA_WIDTH'(CMD_RD))      ||
                     (RX_P_Data == DATA_WIDTH'(CMD_ALU_OP))  ||
                     (RX_P_Data == DATA_WIDTH'(CMD_ALU_NOP)) ||
                     (RX_P_Data == DATA_WIDTH'(CMD_BURST_WR));

  // Bytes arriving while waiting for a response or sending are not part of a frame.
  assign rx_accept = RX_D_VLD && (state_q != StTxSend) && (state_q != StRdWait) &&
                     (state_q != StAluWait);
  assign rsp_event = ((state_q == StRdWait) && RdData_Valid) ||
                     ((state_q == StAluWait) && OUT_Valid);
  assign counting  = (state_q != StIdle) && (state_q != StTxSend);
  assign timeout_fire = counting && !rx_accept && !rsp_event &&
                        (to_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (RX_D_VLD) begin
          if (RX_P_Data == DATA_WIDTH'(CMD_WR))           state_d = StWrAddr;
          else if (RX_P_Data == DATA_WIDTH'(CMD_RD))      state_d = StRdAddr;
          else if (RX_P_Data == DATA_WIDTH'(CMD_ALU_OP))  state_d = StAluA;
          else if (RX_P_Data == DATA_WIDTH'(CMD_ALU_NOP)) state_d = StAluFun;
          else if (RX_P_Data == DATA_WIDTH'(CMD_BURST_WR)) state_d = StBwAddr;
        end
      end
      StWrAddr:  if (RX_D_VLD) state_d = StWrData;
      StWrData:  if (RX_D_VLD) state_d = StIdle;
      StRdAddr:  if (RX_D_VLD) state_d = StRdWait;
      StRdWait:  if (RdData_Valid) state_d = StTxSend;
      StAluA:    if (RX_D_VLD) state_d = StAluB;
      StAluB:    if (RX_D_VLD) state_d = StAluFun;
      StAluFun:  if (RX_D_VLD) state_d = StAluWait;
      StAluWait: if (OUT_Valid) state_d = StTxSend;
      StBwAddr:  if (RX_D_VLD) state_d = StBwCnt;
      StBwCnt: begin
        if (RX_D_VLD) state_d = (RX_P_Data == '0) ? StIdle : StBwData;
      end
      StBwData:  if (RX_D_VLD && (bw_cnt_q == DATA_WIDTH'(1))) state_d = StIdle;
      StTxSend:  if (ser_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (timeout_fire) state_d = StIdle;
  end

  always_comb begin
    to_cnt_d = to_cnt_q + CntW'(1);
    if ((state_d != state_q) || rx_accept || !counting) to_cnt_d = '0;
  end

  always_comb begin
    address_d   = address_q;
    wr_data_d   = wr_data_q;
    alu_fun_d   = alu_fun_q;
    bw_addr_d   = bw_addr_q;
    bw_cnt_d    = bw_cnt_q;
    gating_d    = gating_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    alu_en_d    = 1'b0;
    frame_err_d = 1'b0;
    ser_load    = 1'b0;
    ser_data    = '0;
    ser_cnt     = '0;
    unique case (state_q)
      StIdle:   frame_err_d = RX_D_VLD && !cmd_known;
      StWrAddr: if (RX_D_VLD) address_d = RX_P_Data[ADDR_WIDTH-1:0];
      StWrData: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_Data;
          wr_en_d   = 1'b1;
        end
      end
      StRdAddr: begin
        if (RX_D_VLD) begin
          address_d = RX_P_Data[ADDR_WIDTH-1:0];
          rd_en_d   = 1'b1;
        end
      end
      StRdWait: begin
        if (RdData_Valid) begin
          ser_load = 1'b1;
          ser_data = ResW'(RdData);
          ser_cnt  = NumW'(1);
        end
      end
      StAluA, StAluB: begin
        if (RX_D_VLD) begin
          address_d = (state_q == StAluA) ? ADDR_WIDTH'(ADDR_OP_A) : ADDR_WIDTH'(ADDR_OP_B);
          wr_data_d = RX_P_Data;
          wr_en_d   = 1'b1;
        end
      end
      StAluFun: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_Data[FUN_WIDTH-1:0];
          alu_en_d  = 1'b1;
          gating_d  = 1'b1;
        end
      end
      StAluWait: begin
        if (OUT_Valid) begin
          ser_load = 1'b1;
          ser_data = ALU_OUT;
          ser_cnt  = NumW'(OUT_BYTES);
          gating_d = 1'b0;
        end
      end
      StBwAddr: if (RX_D_VLD) bw_addr_d = RX_P_Data[ADDR_WIDTH-1:0];
      StBwCnt:  if (RX_D_VLD) bw_cnt_d = RX_P_Data;
      StBwData: begin
        if (RX_D_VLD) begin
          address_d = bw_addr_q;
          wr_data_d = RX_P_Data;
          wr_en_d   = 1'b1;
          bw_addr_d = bw_addr_q + ADDR_WIDTH'(1);
          bw_cnt_d  = bw_cnt_q - DATA_WIDTH'(1);
        end
      end
      StTxSend: frame_err_d = RX_D_VLD;
      default: ;
    endcase
    if (timeout_fire) begin
      frame_err_d = 1'b1;
      gating_d    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      address_q    <= '0;
      wr_data_q    <= '0;
      alu_fun_q    <= '0;
      bw_addr_q    <= '0;
      bw_cnt_q     <= '0;
      gating_q     <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      alu_en_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      clk_div_en_q <= 1'b0;
    end else begin
      address_q    <= address_d;
      wr_data_q    <= wr_data_d;
      alu_fun_q    <= alu_fun_d;
      bw_addr_q    <= bw_addr_d;
      bw_cnt_q     <= bw_cnt_d;
      gating_q     <= gating_d;
      wr_en_q      <= wr_en_d;
      rd_en_q      <= rd_en_d;
      alu_en_q     <= alu_en_d;
      frame_err_q  <= frame_err_d;
      clk_div_en_q <= 1'b1;
    end
  end

  sys_ctrl_tx_ser #(
    .DATA_WIDTH(DATA_WIDTH),
    .OUT_BYTES (OUT_BYTES)
  ) u_tx_ser (
    .clk      (CLK),
    .rst      (RST),
    .load     (ser_load),
    .load_data(ser_data),
    .load_cnt (ser_cnt),
    .wfull    (wfull),
    .tx_data  (TX_P_Data),
    .tx_vld   (TX_D_VLD),
    .done     (ser_done)
  );

  assign Address       = address_q;
  assign Wr_En         = wr_en_q;
  assign Rd_En         = rd_en_q;
  assign Wr_Data       = wr_data_q;
  assign ALU_EN        = alu_en_q;
  assign ALU_FUN       = alu_fun_q;
  assign CLK_GATING_EN = gating_q;
  assign clk_div_en    = clk_div_en_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_sys_ctrl_gen2.sv
// Randomised scenario bench for sys_ctrl_gen2; a monitor logs every output transaction and
// each scenario compares the log against the transactions the command frames call for.
module tb_sys_ctrl_gen2;

  localparam int unsigned TO = 16;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RX_P_Data;
  logic        RX_D_VLD;
  logic [7:0]  RdData;
  logic        RdData_Valid;
  logic [15:0] ALU_OUT;
  logic        OUT_Valid;
  logic        wfull;
  logic [3:0]  Address;
  logic        Wr_En;
  logic        Rd_En;
  logic [7:0]  Wr_Data;
  logic        ALU_EN;
  logic [3:0]  ALU_FUN;
  logic        CLK_GATING_EN;
  logic [7:0]  TX_P_Data;
  logic        TX_D_VLD;
  logic        clk_div_en;
  logic        frame_err;

  sys_ctrl_gen2 #(
    .DATA_WIDTH    (8),
    .ADDR_WIDTH    (4),
    .FUN_WIDTH     (4),
    .TIMEOUT_CYCLES(TO),
    .OUT_BYTES     (2)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_P_Data    (RX_P_Data),
    .RX_D_VLD     (RX_D_VLD),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .ALU_OUT      (ALU_OUT),
    .OUT_Valid    (OUT_Valid),
    .wfull        (wfull),
    .Address      (Address),
    .Wr_En        (Wr_En),
    .Rd_En        (Rd_En),
    .Wr_Data      (Wr_Data),
    .ALU_EN       (ALU_EN),
    .ALU_FUN      (ALU_FUN),
    .CLK_GATING_EN(CLK_GATING_EN),
    .TX_P_Data    (TX_P_Data),
    .TX_D_VLD     (TX_D_VLD),
    .clk_div_en   (clk_div_en),
    .frame_err    (frame_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wr_q[$];
  wr_t        exp_wr[$];
  logic [3:0] rd_q[$];
  logic [3:0] alu_q[$];
  logic [7:0] tx_q[$];
  logic [7:0] exp_tx[$];
  int         ferr_cnt;
  int         tx_full_viol;
  int         checks;
  int         errors;

  always @(negedge CLK) begin
    if (Wr_En) wr_q.push_back({Address, Wr_Data});
    if (Rd_En) rd_q.push_back(Address);
    if (ALU_EN) alu_q.push_back(ALU_FUN);
    if (TX_D_VLD) tx_q.push_back(TX_P_Data);
    if (TX_D_VLD && wfull) tx_full_viol++;
    if (frame_err) ferr_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    wr_q.delete();
    exp_wr.delete();
    rd_q.delete();
    alu_q.delete();
    tx_q.delete();
    exp_tx.delete();
    ferr_cnt     = 0;
    tx_full_viol = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Byte is sampled at the next edge; returns 1 time unit after that edge.
  task automatic send_byte(input logic [7:0] b);
    @(posedge CLK);
    #1;
    RX_P_Data = b;
    RX_D_VLD  = 1'b1;
    @(posedge CLK);
    #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    @(posedge CLK);
    #1;
    RdData       = d;
    RdData_Valid = 1'b1;
    @(posedge CLK);
    #1;
    RdData_Valid = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    idle(3);
    @(negedge CLK);
    checks++;
    if ({Wr_En, Rd_En, ALU_EN, CLK_GATING_EN, TX_D_VLD, clk_div_en, frame_err} !== 7'b0) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 0000000",
               {Wr_En, Rd_En, ALU_EN, CLK_GATING_EN, TX_D_VLD, clk_div_en, frame_err});
    end
    checks++;
    if ({Address, Wr_Data, ALU_FUN, TX_P_Data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_buses: got %h expected 000000", {Address, Wr_Data, ALU_FUN, TX_P_Data});
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (clk_div_en !== 1'b1) begin
      errors++;
      $display("FAIL clk_div_en_after_reset: got %b expected 1", clk_div_en);
    end
  endtask

  task automatic test_write();
    logic [7:0] ab, d;
    for (int it = 0; it < 4; it++) begin
      ab = (it == 0) ? 8'h05 : 8'($urandom);
      d  = (it == 0) ? 8'h3C : 8'($urandom);
      clear_mon();
      exp_wr.push_back({ab[3:0], d});
      send_byte(8'hAA);
      idle(2);
      send_byte(ab);
      idle(2);
      send_byte(d);
      @(negedge CLK);
      checks++;
      if ({Wr_En, Address, Wr_Data} !== {1'b1, ab[3:0], d}) begin
        errors++;
        $display("FAIL write_timing: got en=%b a=%h d=%h expected en=1 a=%h d=%h",
                 Wr_En, Address, Wr_Data, ab[3:0], d);
      end
      idle(3);
      checks++;
      if (wr_q.size() != 1 || wr_q[0] !== exp_wr[0] || ferr_cnt != 0) begin
        errors++;
        $display("FAIL write_log: got %0d writes ferr=%0d expected 1 write %h ferr=0",
                 wr_q.size(), ferr_cnt, exp_wr[0]);
      end
    end
  endtask

  task automatic do_read(input logic [7:0] ab, input logic [7:0] d, input int lat);
    int n;
    send_byte(8'hBB);
    send_byte(ab);
    n = 0;
    @(negedge CLK);
    while (!Rd_En && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (Rd_En !== 1'b1 || Address !== ab[3:0]) begin
      errors++;
      $display("FAIL read_strobe: got en=%b a=%h expected en=1 a=%h", Rd_En, Address, ab[3:0]);
    end
    repeat (lat - 1) @(posedge CLK);
    pulse_rd(d);
  endtask

  task automatic test_read();
    logic [7:0] ab, d;
    for (int it = 0; it < 3; it++) begin
      ab = (it == 0) ? 8'h02 : 8'($urandom);
      d  = (it == 0) ? 8'h7E : 8'($urandom);
      clear_mon();
      do_read(ab, d, 3);
      idle(4);
      checks++;
      if (rd_q.size() != 1 || tx_q.size() != 1 || ferr_cnt != 0) begin
        errors++;
        $display("FAIL read_counts: got rd=%0d tx=%0d ferr=%0d expected 1 1 0",
                 rd_q.size(), tx_q.size(), ferr_cnt);
      end else begin
        checks++;
        if (tx_q[0] !== d) begin
          errors++;
          $display("FAIL read_tx_byte: got %h expected %h", tx_q[0], d);
        end
      end
    end
  endtask

  task automatic wait_alu_en();
    int n;
    n = 0;
    @(negedge CLK);
    while (!ALU_EN && n < 20) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic test_alu_op();
    logic [7:0]  a, b, f;
    logic [15:0] res;
    for (int it = 0; it < 2; it++) begin
      a   = (it == 0) ? 8'h10 : 8'($urandom);
      b   = (it == 0) ? 8'h20 : 8'($urandom);
      f   = (it == 0) ? 8'h00 : 8'($urandom);
      res = (it == 0) ? 16'h0030 : 16'($urandom);
      clear_mon();
      exp_wr.push_back({4'd0, a});
      exp_wr.push_back({4'd1, b});
      exp_tx.push_back(res[7:0]);
      exp_tx.push_back(res[15:8]);
      send_byte(8'hCC);
      send_byte(a);
      send_byte(b);
      send_byte(f);
      wait_alu_en();
      checks++;
      if ({ALU_EN, CLK_GATING_EN, ALU_FUN} !== {2'b11, f[3:0]}) begin
        errors++;
        $display("FAIL alu_start: got en=%b gate=%b fun=%h expected 1 1 %h",
                 ALU_EN, CLK_GATING_EN, ALU_FUN, f[3:0]);
      end
      @(posedge CLK);
      #1;
      wfull = 1'b1;
      @(posedge CLK);
      #1;
      ALU_OUT   = res;
      OUT_Valid = 1'b1;
      @(negedge CLK);
      checks++;
      if (CLK_GATING_EN !== 1'b1) begin
        errors++;
        $display("FAIL gating_at_out_valid: got %b expected 1", CLK_GATING_EN);
      end
      @(posedge CLK);
      #1;
      OUT_Valid = 1'b0;
      @(negedge CLK);
      checks++;
      if (CLK_GATING_EN !== 1'b0) begin
        errors++;
        $display("FAIL gating_after_out_valid: got %b expected 0", CLK_GATING_EN);
      end
      idle(2);
      wfull = 1'b0;
      idle(6);
      checks++;
      if (tx_q.size() != 2 || tx_full_viol != 0 || alu_q.size() != 1 || wr_q.size() != 2) begin
        errors++;
        $display("FAIL alu_counts: got tx=%0d viol=%0d alu=%0d wr=%0d expected 2 0 1 2",
                 tx_q.size(), tx_full_viol, alu_q.size(), wr_q.size());
      end else begin
        checks++;
        if (tx_q[0] !== exp_tx[0] || tx_q[1] !== exp_tx[1] || wr_q[0] !== exp_wr[0] ||
            wr_q[1] !== exp_wr[1] || ALU_FUN !== f[3:0]) begin
          errors++;
          $display("FAIL alu_data: got tx=%h%h wr=%h,%h fun=%h expected tx=%h%h wr=%h,%h fun=%h",
                   tx_q[0], tx_q[1], wr_q[0], wr_q[1], ALU_FUN,
                   exp_tx[0], exp_tx[1], exp_wr[0], exp_wr[1], f[3:0]);
        end
      end
    end
  endtask

  task automatic test_alu_nop();
    logic [7:0]  f;
    logic [15:0] res;
    f   = {4'($urandom), 4'($urandom_range(1, 15))};
    res = 16'($urandom);
    clear_mon();
    send_byte(8'hDD);
    send_byte(f);
    wait_alu_en();
    @(posedge CLK);
    #1;
    ALU_OUT   = res;
    OUT_Valid = 1'b1;
    @(posedge CLK);
    #1;
    OUT_Valid = 1'b0;
    idle(5);
    checks++;
    if (tx_q.size() != 2 || wr_q.size() != 0 || alu_q.size() != 1) begin
      errors++;
      $display("FAIL nop_counts: got tx=%0d wr=%0d alu=%0d expected 2 0 1",
               tx_q.size(), wr_q.size(), alu_q.size());
    end else begin
      checks++;
      if ({tx_q[0], tx_q[1], alu_q[0]} !== {res[7:0], res[15:8], f[3:0]}) begin
        errors++;
        $display("FAIL nop_data: got %h%h fun=%h expected %h%h fun=%h",
                 tx_q[0], tx_q[1], alu_q[0], res[7:0], res[15:8], f[3:0]);
      end
    end
  endtask

  task automatic test_burst();
    logic [7:0] bd[8];
    int         a, n;
    for (int it = 0; it < 3; it++) begin
      a = (it == 0) ? 14 : int'($urandom_range(0, 15));
      n = (it == 0) ? 3 : int'($urandom_range(1, 7));
      for (int k = 0; k < 8; k++) bd[k] = (it == 0) ? 8'(8'hA1 + k) : 8'($urandom);
      clear_mon();
      for (int k = 0; k < n; k++) exp_wr.push_back({4'((a + k) % 16), bd[k]});
      send_byte(8'hEE);
      send_byte(8'(a));
      send_byte(8'(n));
      for (int k = 0; k < n; k++) send_byte(bd[k]);
      idle(3);
      checks++;
      if (wr_q.size() != exp_wr.size()) begin
        errors++;
        $display("FAIL burst_count: got %0d writes expected %0d", wr_q.size(), exp_wr.size());
      end else begin
        for (int k = 0; k < n; k++) begin
          checks++;
          if (wr_q[k] !== exp_wr[k]) begin
            errors++;
            $display("FAIL burst_write_%0d: got %h expected %h", k, wr_q[k], exp_wr[k]);
          end
        end
      end
    end
    clear_mon();
    send_byte(8'hEE);
    send_byte(8'h04);
    send_byte(8'h00);
    idle(2);
    send_byte(8'hAA);
    send_byte(8'h07);
    send_byte(8'h5B);
    idle(3);
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {4'h7, 8'h5B} || ferr_cnt != 0) begin
      errors++;
      $display("FAIL burst_zero: got %0d writes ferr=%0d expected 1 write 75b ferr=0",
               wr_q.size(), ferr_cnt);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    d = 8'($urandom);
    clear_mon();
    send_byte(8'hAA);
    send_byte(8'h03);
    idle(TO - 3);
    checks++;
    if (ferr_cnt != 0) begin
      errors++;
      $display("FAIL timeout_early: got ferr=%0d expected 0", ferr_cnt);
    end
    idle(8);
    checks++;
    if (ferr_cnt != 1 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_fire: got ferr=%0d wr=%0d expected 1 0", ferr_cnt, wr_q.size());
    end
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(d);
    idle(3);
    checks++;
    if (wr_q.size() != 1 || wr_q[0] !== {4'h1, d} || ferr_cnt != 1) begin
      errors++;
      $display("FAIL timeout_recover: got %0d writes ferr=%0d expected write 1%h ferr=1",
               wr_q.size(), ferr_cnt, d);
    end
    clear_mon();
    send_byte(8'hBB);
    send_byte(8'h02);
    idle(TO + 6);
    pulse_rd(8'h99);
    idle(4);
    checks++;
    if (ferr_cnt != 1 || tx_q.size() != 0 || rd_q.size() != 1) begin
      errors++;
      $display("FAIL timeout_late_rsp: got ferr=%0d tx=%0d rd=%0d expected 1 0 1",
               ferr_cnt, tx_q.size(), rd_q.size());
    end
  endtask

  task automatic test_unknown();
    logic [7:0] b;
    b = 8'h5A;
    for (int it = 0; it < 2; it++) begin
      clear_mon();
      send_byte(b);
      idle(3);
      checks++;
      if (ferr_cnt != 1 || wr_q.size() != 0 || rd_q.size() != 0 || alu_q.size() != 0) begin
        errors++;
        $display("FAIL unknown_cmd_%h: got ferr=%0d wr=%0d rd=%0d alu=%0d expected 1 0 0 0",
                 b, ferr_cnt, wr_q.size(), rd_q.size(), alu_q.size());
      end
      do b = 8'($urandom);
      while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD || b == 8'hEE);
    end
  endtask

  task automatic test_rst_mid();
    logic [7:0] d;
    d = 8'($urandom);
    clear_mon();
    send_byte(8'hBB);
    RST = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({Address, Wr_En, Rd_En, Wr_Data, ALU_EN, ALU_FUN, CLK_GATING_EN, TX_P_Data, TX_D_VLD,
         clk_div_en, frame_err} !== 31'h0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got a=%h fun=%h div=%b expected all zero",
               Address, ALU_FUN, clk_div_en);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    idle(2);
    do_read(8'h01, d, 2);
    idle(4);
    checks++;
    if (tx_q.size() != 1 || rd_q.size() != 1 || ferr_cnt != 0) begin
      errors++;
      $display("FAIL rst_mid_recover: got tx=%0d rd=%0d ferr=%0d expected 1 1 0",
               tx_q.size(), rd_q.size(), ferr_cnt);
    end else begin
      checks++;
      if (tx_q[0] !== d || rd_q[0] !== 4'h1) begin
        errors++;
        $display("FAIL rst_mid_data: got tx=%h rd=%h expected %h 1", tx_q[0], rd_q[0], d);
      end
    end
  endtask

  task automatic test_tx_drop();
    logic [7:0] d, d2;
    d  = 8'($urandom);
    d2 = 8'($urandom);
    clear_mon();
    wfull = 1'b1;
    do_read(8'h0C, d, 1);
    idle(3);
    send_byte(8'hAA);
    idle(2);
    wfull = 1'b0;
    idle(3);
    send_byte(8'hAA);
    send_byte(8'h09);
    send_byte(d2);
    idle(3);
    checks++;
    if (tx_q.size() != 1 || tx_full_viol != 0 || ferr_cnt != 1 || wr_q.size() != 1) begin
      errors++;
      $display("FAIL tx_drop_counts: got tx=%0d viol=%0d ferr=%0d wr=%0d expected 1 0 1 1",
               tx_q.size(), tx_full_viol, ferr_cnt, wr_q.size());
    end else begin
      checks++;
      if (tx_q[0] !== d || wr_q[0] !== {4'h9, d2}) begin
        errors++;
        $display("FAIL tx_drop_data: got tx=%h wr=%h expected %h 9%h", tx_q[0], wr_q[0], d, d2);
      end
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    RST          = 1'b1;
    RX_P_Data    = '0;
    RX_D_VLD     = 1'b0;
    RdData       = '0;
    RdData_Valid = 1'b0;
    ALU_OUT      = '0;
    OUT_Valid    = 1'b0;
    wfull        = 1'b0;
    clear_mon();
    test_reset();
    test_write();
    test_read();
    test_alu_op();
    test_alu_nop();
    test_burst();
    test_timeout();
    test_unknown();
    test_rst_mid();
    test_tx_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
